// File: rtl/qspi_pkg.sv
// Shared types and helpers for the QSPI shift engine and its lane multiplexer.
package qspi_pkg;

  typedef enum logic [1:0] {
    LANE_1 = 2'b00,
    LANE_2 = 2'b01,
    LANE_4 = 2'b10
  } lane_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_e;

  localparam logic DIR_TX = 1'b0;
  localparam logic DIR_RX = 1'b1;

  function automatic logic [2:0] lane_count(input lane_mode_e mode);
    case (mode)
      LANE_2:  return 3'd2;
      LANE_4:  return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/qspi_lane_mux.sv
// Combinational pad mapping: shift register MSBs to IO lanes, IO lanes to the RX capture group.
module qspi_lane_mux
  import qspi_pkg::*;
(
  input  lane_mode_e  lane,
  input  logic        tx_en,
  input  logic [3:0]  tx_msbs,
  input  logic [3:0]  io_in,
  output logic [3:0]  io_out,
  output logic [3:0]  io_oe,
  output logic [3:0]  rx_bits
);

  logic [3:0] lane_mask;

  // io0 carries the register MSB, so the nibble is bit-reversed onto the pads.
  always_comb begin
    lane_mask = 4'b0001;
    rx_bits   = 4'b0000;
    case (lane)
      LANE_2: begin
        lane_mask = 4'b0011;
        rx_bits   = {2'b00, io_in[0], io_in[1]};
      end
      LANE_4: begin
        lane_mask = 4'b1111;
        rx_bits   = {io_in[0], io_in[1], io_in[2], io_in[3]};
      end
      default: begin
        lane_mask = 4'b0001;
        rx_bits   = {3'b000, io_in[1]};
      end
    endcase

    io_oe  = tx_en ? lane_mask : 4'b0000;
    io_out = tx_en ? ({tx_msbs[0], tx_msbs[1], tx_msbs[2], tx_msbs[3]} & lane_mask) : 4'b0000;
  end

endmodule

// File: rtl/qspi_shift_engine.sv
// Bidirectional 1/2/4-lane QSPI shift engine with programmable bit count and done/rx_valid handshake.
module qspi_shift_engine
  import qspi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              dir,
  input  logic [1:0]        lane_mode,
  input  logic [CNT_W-1:0]  xfer_bits,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              sclk_rise,
  input  logic              sclk_fall,
  input  logic [3:0]        io_in,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oe,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid
);

  localparam logic [CNT_W-1:0] DATA_W_CNT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  shift_state_e      state;
  logic              dir_q;
  lane_mode_e        lane_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  eff_bits;
  logic [DATA_W-1:0] shift_reg;

  lane_mode_e        lane_in;
  logic [CNT_W-1:0]  lane_in_cnt;
  logic [CNT_W-1:0]  clamp_bits;
  logic [CNT_W-1:0]  eff_start;
  logic [CNT_W-1:0]  lane_step;
  logic [3:0]        rx_bits;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] rx_mask;
  logic              tx_active;

  // DATA_W is a multiple of 4, so rounding the clamped count up never overflows CNT_W bits.
  always_comb begin
    case (lane_mode)
      2'b01:   lane_in = LANE_2;
      2'b10:   lane_in = LANE_4;
      default: lane_in = LANE_1;
    endcase
    lane_in_cnt = CNT_W'(lane_count(lane_in));
    clamp_bits  = (xfer_bits > DATA_W_CNT) ? DATA_W_CNT : xfer_bits;
    eff_start   = (clamp_bits + lane_in_cnt - CNT_ONE) & ~(lane_in_cnt - CNT_ONE);
  end

  always_comb begin
    lane_step = CNT_W'(lane_count(lane_q));
    rx_next   = (shift_reg << lane_step) | DATA_W'(rx_bits);
    rx_mask   = ~({DATA_W{1'b1}} << eff_bits);
    tx_active = (state == SHIFT) && (dir_q == DIR_TX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dir_q     <= DIR_TX;
      lane_q    <= LANE_1;
      bit_cnt   <= '0;
      eff_bits  <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            dir_q     <= dir;
            lane_q    <= lane_in;
            shift_reg <= tx_data;
            bit_cnt   <= eff_start;
            eff_bits  <= eff_start;
            state     <= (eff_start == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          // A rise in the same cycle as a fall takes priority; the fall is dropped.
          if (abort) begin
            state <= IDLE;
          end else if (sclk_rise) begin
            bit_cnt <= bit_cnt - lane_step;
            if (dir_q == DIR_RX) begin
              shift_reg <= rx_next;
            end
            if (bit_cnt == lane_step) begin
              state <= DONE;
              if (dir_q == DIR_RX) begin
                rx_data <= rx_next & rx_mask;
              end
            end
          end else if (sclk_fall && (bit_cnt != '0) && (dir_q == DIR_TX)) begin
            shift_reg <= shift_reg << lane_step;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE) && !abort;
  assign rx_valid = done && (dir_q == DIR_RX);

  qspi_lane_mux u_lane_mux (
    .lane    (lane_q),
    .tx_en   (tx_active),
    .tx_msbs (shift_reg[DATA_W-1 -: 4]),
    .io_in   (io_in),
    .io_out  (io_out),
    .io_oe   (io_oe),
    .rx_bits (rx_bits)
  );

endmodule

// File: tb/tb_qspi_shift_engine.sv
// Scoreboard bench for qspi_shift_engine: directed transfers, completions checked by a done monitor.
module tb_qspi_shift_engine;

  localparam int DW = 32;
  localparam int CW = $clog2(DW + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          dir;
  logic [1:0]    lane_mode;
  logic [CW-1:0] xfer_bits;
  logic [DW-1:0] tx_data;
  logic          sclk_rise;
  logic          sclk_fall;
  logic [3:0]    io_in;
  logic [3:0]    io_out;
  logic [3:0]    io_oe;
  logic          busy;
  logic          done;
  logic [DW-1:0] rx_data;
  logic          rx_valid;

  typedef struct {
    logic          rx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;
  logic [DW-1:0] last_rx = '0;

  qspi_shift_engine #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .dir       (dir),
    .lane_mode (lane_mode),
    .xfer_bits (xfer_bits),
    .tx_data   (tx_data),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oe     (io_oe),
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic d, input logic [1:0] m, input logic [CW-1:0] bits,
                               input logic [DW-1:0] tx, input bit expect_done,
                               input logic [DW-1:0] exp_rx);
    exp_t e;
    if (expect_done) begin
      e.rx   = d;
      e.data = exp_rx;
      exp_q.push_back(e);
    end
    dir       = d;
    lane_mode = m;
    xfer_bits = bits;
    tx_data   = tx;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic rise(input logic [3:0] pads);
    io_in     = pads;
    sclk_rise = 1'b1;
    tick();
    sclk_rise = 1'b0;
  endtask

  task automatic fall();
    sclk_fall = 1'b1;
    tick();
    sclk_fall = 1'b0;
  endtask

  // Every completion pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no completion at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("sb_rx_valid", DW'(rx_valid), DW'(e.rx));
        checkOutput("sb_rx_data", rx_data, e.data);
      end
    end
    if (rst_n && rx_valid) checkOutput("rx_valid_with_done", DW'(done), DW'(1));
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] quad_tx_exp [8];
    logic [3:0] quad_rx_pads[8];
    logic [3:0] dual_exp    [4];
    logic [3:0] single_bits [8];
    quad_tx_exp  = '{4'h5, 4'hA, 4'h3, 4'hC, 4'h8, 4'h4, 4'hC, 4'h2};
    quad_rx_pads = '{4'h8, 4'h4, 4'hC, 4'h2, 4'h5, 4'hD, 4'h3, 4'hB};
    dual_exp     = '{4'h1, 4'h3, 4'h2, 4'h0};
    single_bits  = '{4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; dir = 1'b0; lane_mode = 2'b00;
    xfer_bits = '0; tx_data = '0; sclk_rise = 1'b0; sclk_fall = 1'b0; io_in = 4'h0;
    #1;
    checkOutput("reset_io_out", DW'(io_out), 0);
    checkOutput("reset_io_oe", DW'(io_oe), 0);
    checkOutput("reset_busy", DW'(busy), 0);
    checkOutput("reset_done", DW'(done), 0);
    checkOutput("reset_rx_valid", DW'(rx_valid), 0);
    checkOutput("reset_rx_data", rx_data, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Quad TX, full word
    applyStimulus(1'b0, 2'b10, 6'd32, 32'hA5C3_1234, 1'b1, last_rx);
    checkOutput("quad_busy", DW'(busy), 1);
    checkOutput("quad_io_oe", DW'(io_oe), 32'hF);
    for (int i = 0; i < 8; i++) begin
      checkOutput("quad_io_out", DW'(io_out), DW'(quad_tx_exp[i]));
      rise(4'h0);
      if (i < 7) begin
        checkOutput("quad_no_early_done", DW'(done), 0);
        fall();
      end
    end
    checkOutput("quad_done", DW'(done), 1);
    checkOutput("quad_oe_off_in_done", DW'(io_oe), 0);
    tick();
    checkOutput("quad_busy_after", DW'(busy), 0);
    checkOutput("quad_done_one_cycle", DW'(done), 0);

    // Single RX, 8 bits on io_in[1]; stale tx_data bits must be masked off
    applyStimulus(1'b1, 2'b00, 6'd8, 32'hFFFF_FFFF, 1'b1, 32'h0000_00B2);
    for (int i = 0; i < 8; i++) begin
      checkOutput("single_rx_io_oe", DW'(io_oe), 0);
      rise({2'b10, single_bits[i][0], 1'b1});
      if (i < 7) fall();
    end
    checkOutput("single_rx_done", DW'(done), 1);
    checkOutput("single_rx_valid", DW'(rx_valid), 1);
    checkOutput("single_rx_data", rx_data, 32'h0000_00B2);
    last_rx = 32'h0000_00B2;
    tick();
    checkOutput("single_rx_valid_one_cycle", DW'(rx_valid), 0);

    // Dual TX, 7 bits rounds up to 8 (4 rises)
    applyStimulus(1'b0, 2'b01, 6'd7, 32'hB400_0000, 1'b1, last_rx);
    checkOutput("dual_io_oe", DW'(io_oe), 32'h3);
    for (int i = 0; i < 4; i++) begin
      checkOutput("dual_io_out", DW'(io_out), DW'(dual_exp[i]));
      rise(4'h0);
      if (i < 3) begin
        checkOutput("dual_no_early_done", DW'(done), 0);
        fall();
      end
    end
    checkOutput("dual_done_after_4", DW'(done), 1);
    tick();

    // lane_mode 11 behaves as single
    applyStimulus(1'b0, 2'b11, 6'd2, 32'h8000_0000, 1'b1, last_rx);
    checkOutput("mode11_io_oe", DW'(io_oe), 32'h1);
    checkOutput("mode11_io_out0", DW'(io_out), 32'h1);
    rise(4'h0);
    fall();
    checkOutput("mode11_io_out1", DW'(io_out), 32'h0);
    rise(4'h0);
    checkOutput("mode11_done", DW'(done), 1);
    tick();

    // Zero-length transfer completes immediately
    applyStimulus(1'b0, 2'b10, 6'd0, 32'hFFFF_FFFF, 1'b1, last_rx);
    checkOutput("zero_done", DW'(done), 1);
    checkOutput("zero_busy", DW'(busy), 1);
    checkOutput("zero_io_oe", DW'(io_oe), 0);
    tick();
    checkOutput("zero_busy_after", DW'(busy), 0);

    // Quad RX, 40 bits clamps to 32 (8 rises)
    applyStimulus(1'b1, 2'b10, 6'd40, 32'h0, 1'b1, 32'h1234_ABCD);
    for (int i = 0; i < 8; i++) begin
      rise(quad_rx_pads[i]);
      if (i < 7) begin
        checkOutput("clamp_no_early_done", DW'(done), 0);
        fall();
      end
    end
    checkOutput("clamp_done", DW'(done), 1);
    last_rx = 32'h1234_ABCD;
    tick();

    // Abort after 3 quad RX rises: no completion, rx_data kept
    applyStimulus(1'b1, 2'b10, 6'd32, 32'h0, 1'b0, last_rx);
    for (int i = 0; i < 3; i++) begin
      rise(4'hF);
      fall();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_busy", DW'(busy), 0);
    checkOutput("abort_rx_data_kept", rx_data, last_rx);
    tick();

    // Abort during TX drops io_oe next cycle
    applyStimulus(1'b0, 2'b10, 6'd32, 32'hFFFF_FFFF, 1'b0, last_rx);
    checkOutput("abort_tx_oe_on", DW'(io_oe), 32'hF);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_tx_oe_off", DW'(io_oe), 0);

    // Start together with abort in IDLE is dropped; start while busy is ignored
    abort = 1'b1;
    applyStimulus(1'b0, 2'b10, 6'd32, 32'hFFFF_FFFF, 1'b0, last_rx);
    abort = 1'b0;
    checkOutput("start_abort_idle", DW'(busy), 0);
    checkOutput("start_abort_oe", DW'(io_oe), 0);

    // Async reset mid quad TX, then a clean transfer
    applyStimulus(1'b0, 2'b10, 6'd32, 32'hA5C3_1234, 1'b0, last_rx);
    rise(4'h0);
    fall();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_io_oe", DW'(io_oe), 0);
    checkOutput("rst_io_out", DW'(io_out), 0);
    checkOutput("rst_busy", DW'(busy), 0);
    checkOutput("rst_rx_data", rx_data, 0);
    last_rx = '0;
    #2;
    rst_n = 1'b1;
    tick();

    applyStimulus(1'b0, 2'b10, 6'd8, 32'h3C00_0000, 1'b1, last_rx);
    applyStimulus(1'b0, 2'b00, 6'd8, 32'h0, 1'b0, last_rx);
    checkOutput("post_rst_busy_start_ignored", DW'(io_oe), 32'hF);
    checkOutput("post_rst_nib0", DW'(io_out), 32'hC);
    sclk_fall = 1'b1;
    rise(4'h0);
    sclk_fall = 1'b0;
    checkOutput("rise_fall_same_cycle", DW'(io_out), 32'hC);
    fall();
    checkOutput("post_rst_nib1", DW'(io_out), 32'h3);
    rise(4'h0);
    checkOutput("post_rst_done", DW'(done), 1);
    tick();
    tick();

    checkOutput("sb_queue_empty", DW'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
